// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Default constants assume a 50 MHz clock.
package btn_pkg;

  // Per-channel debounce FSM states
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 50 MHz defaults: 1.5 ms debounce, 0.5 s first repeat, 0.1 s repeat period
  localparam int DEF_NUM_BTN         = 4;
  localparam int DEF_ACTIVE_LOW      = 1;
  localparam int DEF_DEBOUNCE_CYCLES = 75000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_RATE     = 5000000;

  // Counter width: ceil(log2(max)), at least one bit. Counters only ever
  // hold max-1 down to 0, so this is always wide enough.
  function automatic int btn_cnt_w(input int max);
    int w;
    w = 1;
    while ((w < 31) && ((1 << w) < max)) w++;
    return w;
  endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One button channel: 2-flop synchroniser, debounce FSM, debounce and
// repeat counters, registered level and tick outputs.
// Optional feature macro: BTN_AUTOREPEAT_EN (compiles in the repeat counter
// and repeat_tick; otherwise repeat_tick is tied low).
module button_debounce_chan
  import btn_pkg::*;
#(
  parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic held,
  output logic press_tick,
  output logic release_tick,
  output logic repeat_tick
);

  localparam int CNT_MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX    = (CNT_MAX_DR > REPEAT_RATE) ? CNT_MAX_DR : REPEAT_RATE;
  localparam int CNT_W      = btn_cnt_w(CNT_MAX);

  localparam logic [CNT_W-1:0] DLOAD    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             IDLE_LVL = (ACTIVE_LOW != 0);

  logic [1:0]       sync_q;
  logic             p;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             held_q, held_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RDLOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RRLOAD = CNT_W'(REPEAT_RATE - 1);
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             repeat_q, repeat_d;
`endif

  // Bring the raw pin into the clock domain; reset to the released level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {2{IDLE_LVL}};
    else          sync_q <= {sync_q[0], btn_in};
  end

  // Polarity-corrected pressed flag (1 = pressed)
  assign p = sync_q[1] ^ IDLE_LVL;

  // Next-state, counter and tick decode; zero test always precedes decrement
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    held_d    = held_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rcnt_d    = rcnt_q;
    repeat_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (p) begin
          state_d = PRESS_WAIT;
          dcnt_d  = DLOAD;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_d = IDLE;
        end else if (dcnt_q == '0) begin
          state_d = HELD;
          press_d = 1'b1;
          held_d  = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          rcnt_d  = RDLOAD;
`endif
        end else begin
          dcnt_d = dcnt_q - CNT_W'(1);
        end
      end
      HELD: begin
        if (!p) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = DLOAD;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (rcnt_q == '0) begin
          repeat_d = 1'b1;
          rcnt_d   = RRLOAD;
        end else begin
          rcnt_d = rcnt_q - CNT_W'(1);
        end
`endif
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_d = HELD;
        end else if (dcnt_q == '0) begin
          state_d   = IDLE;
          release_d = 1'b1;
          held_d    = 1'b0;
        end else begin
          dcnt_d = dcnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dcnt_q    <= '0;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  // Repeat counter and tick, frozen outside HELD
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_tick = repeat_q;
`else
  assign repeat_tick = 1'b0;
`endif

  assign held         = held_q;
  assign press_tick   = press_q;
  assign release_tick = release_q;

endmodule

// File: rtl/button_debounce_array.sv
// Multi-channel push-button conditioner: NUM_BTN independent debounce
// channels with press/release/repeat ticks and a clean held level.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat ticks while held).
module button_debounce_array
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] held,
  output logic [NUM_BTN-1:0] press_tick,
  output logic [NUM_BTN-1:0] release_tick,
  output logic [NUM_BTN-1:0] repeat_tick
);

  // Elaboration-time parameter legality checks
  if (NUM_BTN < 1) begin : g_bad_num_btn
    $error("button_debounce_array: NUM_BTN must be >= 1");
  end
  if ((ACTIVE_LOW != 0) && (ACTIVE_LOW != 1)) begin : g_bad_active_low
    $error("button_debounce_array: ACTIVE_LOW must be 0 or 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_debounce_array: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_delay
    $error("button_debounce_array: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_RATE < 1) begin : g_bad_rate
    $error("button_debounce_array: REPEAT_RATE must be >= 1");
  end

  // One independent conditioner per button; no cross-channel interaction
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    button_debounce_chan #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .btn_in       (btn_in[i]),
      .held         (held[i]),
      .press_tick   (press_tick[i]),
      .release_tick (release_tick[i]),
      .repeat_tick  (repeat_tick[i])
    );
  end

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed self-checking bench for button_debounce_array.
// NUM_BTN=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
// Repeat expectations follow BTN_AUTOREPEAT_EN as compiled.
module tb_button_debounce_array;

  logic       clk;
  logic       reset_n;
  logic [1:0] btn_in;
  logic [1:0] held;
  logic [1:0] press_tick;
  logic [1:0] release_tick;
  logic [1:0] repeat_tick;

  int errors = 0;
  int checks = 0;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  button_debounce_array #(
    .NUM_BTN         (2),
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_RATE     (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_in       (btn_in),
    .held         (held),
    .press_tick   (press_tick),
    .release_tick (release_tick),
    .repeat_tick  (repeat_tick)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge (inputs driven and outputs sampled here)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs are zero while reset is held, and stay zero with buttons released
  task automatic test_reset();
    reset_n = 1'b0;
    btn_in  = 2'b11;
    #2;
    if ({held, press_tick, release_tick, repeat_tick} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%h exp=00", {held, press_tick, release_tick, repeat_tick});
    end
    checks++;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    if ({held, press_tick, release_tick, repeat_tick} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got=%h exp=00", {held, press_tick, release_tick, repeat_tick});
    end
    checks++;
  endtask

  // Clean press then release on ch0: ticks after edge k+6
  task automatic test_clean_press();
    btn_in[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (press_tick[0] !== (i == 7)) begin
        errors++;
        $display("[TB] FAIL clean_press_tick i=%0d got=%b exp=%b", i, press_tick[0], (i == 7));
      end
      checks++;
      if (held[0] !== (i >= 7)) begin
        errors++;
        $display("[TB] FAIL clean_press_held i=%0d got=%b exp=%b", i, held[0], (i >= 7));
      end
      checks++;
    end
    btn_in[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (release_tick[0] !== (i == 7)) begin
        errors++;
        $display("[TB] FAIL clean_release_tick i=%0d got=%b exp=%b", i, release_tick[0], (i == 7));
      end
      checks++;
      if (held[0] !== (i < 7)) begin
        errors++;
        $display("[TB] FAIL clean_release_held i=%0d got=%b exp=%b", i, held[0], (i < 7));
      end
      checks++;
      if (press_tick[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL clean_release_nopress i=%0d got=%b exp=0", i, press_tick[0]);
      end
      checks++;
    end
  endtask

  // Three-cycle glitch on ch1 is rejected
  task automatic test_glitch();
    btn_in[1] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) btn_in[1] = 1'b1;
      if (press_tick[1] !== 1'b0 || held[1] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL glitch i=%0d got press=%b held=%b exp press=0 held=0", i, press_tick[1], held[1]);
      end
      checks++;
    end
  endtask

  // Press ch0 and wait out the debounce; returns just after the press edge
  task automatic press_ch0();
    btn_in[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 7 && press_tick[0] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL press_ch0_tick got=%b exp=1", press_tick[0]);
      end
    end
    checks++;
  endtask

  // Release ch0 and check the release tick after the normal latency
  task automatic release_ch0();
    btn_in[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (release_tick[0] !== (i == 7)) begin
        errors++;
        $display("[TB] FAIL release_ch0_tick i=%0d got=%b exp=%b", i, release_tick[0], (i == 7));
      end
      checks++;
    end
  endtask

  // Holding ch0: repeats at +10, +13, +16, ... after press_tick
  task automatic test_autorepeat();
    logic exp;
    press_ch0();
    for (int t = 1; t <= 25; t++) begin
      tick();
      exp = REP_EN && (t >= 10) && ((t - 10) % 3 == 0);
      if (repeat_tick[0] !== exp) begin
        errors++;
        $display("[TB] FAIL repeat t=%0d got=%b exp=%b", t, repeat_tick[0], exp);
      end
      checks++;
      if (press_tick[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL repeat_nopress t=%0d got=%b exp=0", t, press_tick[0]);
      end
      checks++;
    end
    release_ch0();
  endtask

  // Two-cycle release bounce while held: no ticks, repeat delayed by 3 frozen edges
  task automatic test_release_bounce();
    logic exp;
    press_ch0();
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 4) btn_in[0] = 1'b1;
      if (t == 6) btn_in[0] = 1'b0;
      exp = REP_EN && (t == 13 || t == 16 || t == 19);
      if (repeat_tick[0] !== exp) begin
        errors++;
        $display("[TB] FAIL bounce_repeat t=%0d got=%b exp=%b", t, repeat_tick[0], exp);
      end
      checks++;
      if (press_tick[0] !== 1'b0 || release_tick[0] !== 1'b0 || held[0] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bounce_ticks t=%0d got press=%b rel=%b held=%b exp 0 0 1",
                 t, press_tick[0], release_tick[0], held[0]);
      end
      checks++;
    end
    release_ch0();
  endtask

  // Both channels pressed and released on the same edge report together
  task automatic test_back_to_back();
    btn_in = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (press_tick !== ((i == 7) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("[TB] FAIL both_press i=%0d got=%b exp=%b", i, press_tick, ((i == 7) ? 2'b11 : 2'b00));
      end
      checks++;
    end
    btn_in = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (release_tick !== ((i == 7) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("[TB] FAIL both_release i=%0d got=%b exp=%b", i, release_tick, ((i == 7) ? 2'b11 : 2'b00));
      end
      checks++;
    end
  endtask

  // Reset while ch1 held and ch0 mid-debounce; ch0 held through reset re-presses
  task automatic test_reset_mid();
    btn_in[1] = 1'b0;
    repeat (7) tick();
    if (held[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_ch1_held got=%b exp=1", held[1]);
    end
    checks++;
    btn_in[0] = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    if ({held, press_tick, release_tick, repeat_tick} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL mid_reset_async got=%h exp=00", {held, press_tick, release_tick, repeat_tick});
    end
    checks++;
    btn_in[1] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if ({held, press_tick, release_tick, repeat_tick} !== 8'h00) begin
        errors++;
        $display("[TB] FAIL mid_reset_hold i=%0d got=%h exp=00", i, {held, press_tick, release_tick, repeat_tick});
      end
      checks++;
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (press_tick !== ((i == 7) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("[TB] FAIL post_reset_press i=%0d got=%b exp=%b", i, press_tick, ((i == 7) ? 2'b01 : 2'b00));
      end
      checks++;
      if (release_tick !== 2'b00) begin
        errors++;
        $display("[TB] FAIL post_reset_norelease i=%0d got=%b exp=00", i, release_tick);
      end
      checks++;
    end
    release_ch0();
  endtask

  // Run all scenarios in order, then report
  initial begin
    reset_n = 1'b0;
    btn_in  = 2'b11;
    test_reset();
    test_clean_press();
    test_glitch();
    test_autorepeat();
    test_release_bounce();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
